// File: rtl/nand4_x4_cell.sv
// Four-input NAND X4 cell wrapper: combinational ZN plus a registered copy and an all-low flag.
// Define NAND4_X4_TOGGLE_CNT_EN to add the saturating TOG_CNT activity counter.
module nand4_x4_cell #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  input  logic [WIDTH-1:0] A4,
  input  logic             EN,
  output logic [WIDTH-1:0] ZN,
  output logic [WIDTH-1:0] ZN_Q,
`ifdef NAND4_X4_TOGGLE_CNT_EN
  output logic             ALL_HI_Q,
  output logic [CNT_W-1:0] TOG_CNT
`else
  output logic             ALL_HI_Q
`endif
);

  logic [WIDTH-1:0] zn_q;
  logic             all_hi_q;

  // Four-state AND semantics: any 0 input forces the bit high even when others are X.
  assign ZN = ~(A1 & A2 & A3 & A4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zn_q     <= '1;
      all_hi_q <= 1'b0;
    end else if (EN) begin
      zn_q     <= ZN;
      all_hi_q <= (ZN == '0);
    end
  end

  assign ZN_Q     = zn_q;
  assign ALL_HI_Q = all_hi_q;

`ifdef NAND4_X4_TOGGLE_CNT_EN
  logic [CNT_W-1:0] tog_cnt_q;

  // Counts enabled edges where the captured value changes; sticks at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_cnt_q <= '0;
    end else if (EN && (ZN != zn_q) && (tog_cnt_q != '1)) begin
      tog_cnt_q <= tog_cnt_q + CNT_W'(1);
    end
  end

  assign TOG_CNT = tog_cnt_q;
`endif

endmodule

// File: tb/tb_nand4_x4_cell.sv
// Self-checking bench for nand4_x4_cell: directed cases plus randomized stimulus against a
// behavioural model, on a WIDTH=1/CNT_W=2 instance and a WIDTH=4 instance.
module tb_nand4_x4_cell;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       a1_1, a2_1, a3_1, a4_1;
  logic [3:0] a1_4, a2_4, a3_4, a4_4;
  logic       zn_1, znq_1, allhi_1;
  logic [3:0] zn_4, znq_4;
  logic       allhi_4;
`ifdef NAND4_X4_TOGGLE_CNT_EN
  logic [1:0]  cnt_1;
  logic [15:0] cnt_4;
`endif

  int npass = 0;
  int ntot  = 0;

  // Reference state
  logic        exp_q1, exp_all1, exp_all4;
  logic [3:0]  exp_q4;
  int          exp_cnt1, exp_cnt4;

  always #5 clk = ~clk;

  nand4_x4_cell #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .A1       (a1_1),
    .A2       (a2_1),
    .A3       (a3_1),
    .A4       (a4_1),
    .EN       (en),
    .ZN       (zn_1),
    .ZN_Q     (znq_1),
`ifdef NAND4_X4_TOGGLE_CNT_EN
    .ALL_HI_Q (allhi_1),
    .TOG_CNT  (cnt_1)
`else
    .ALL_HI_Q (allhi_1)
`endif
  );

  nand4_x4_cell #(.WIDTH(4), .CNT_W(16)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .A1       (a1_4),
    .A2       (a2_4),
    .A3       (a3_4),
    .A4       (a4_4),
    .EN       (en),
    .ZN       (zn_4),
    .ZN_Q     (znq_4),
`ifdef NAND4_X4_TOGGLE_CNT_EN
    .ALL_HI_Q (allhi_4),
    .TOG_CNT  (cnt_4)
`else
    .ALL_HI_Q (allhi_4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // A bit is low only when all four operand bits are high.
  function automatic logic [3:0] nand_ref(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] d);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]) + int'(d[i]);
      r[i] = (ones == 4) ? 1'b0 : 1'b1;
    end
    return r;
  endfunction

  function automatic logic [0:0] ref1();
    logic [3:0] r;
    r = nand_ref({3'b0, a1_1}, {3'b0, a2_1}, {3'b0, a3_1}, {3'b0, a4_1});
    return r[0];
  endfunction

  task automatic model_reset();
    exp_q1 = 1'b1; exp_q4 = 4'hF;
    exp_all1 = 1'b0; exp_all4 = 1'b0;
    exp_cnt1 = 0; exp_cnt4 = 0;
  endtask

  task automatic check_zn();
    logic [3:0] z4;
    z4 = nand_ref(a1_4, a2_4, a3_4, a4_4);
    chk("zn_w1", {31'b0, zn_1}, {31'b0, ref1()});
    chk("zn_w4", {28'b0, zn_4}, {28'b0, z4});
  endtask

  task automatic check_regs();
    chk("znq_w1", {31'b0, znq_1}, {31'b0, exp_q1});
    chk("allhi_w1", {31'b0, allhi_1}, {31'b0, exp_all1});
    chk("znq_w4", {28'b0, znq_4}, {28'b0, exp_q4});
    chk("allhi_w4", {31'b0, allhi_4}, {31'b0, exp_all4});
`ifdef NAND4_X4_TOGGLE_CNT_EN
    chk("cnt_w1", {30'b0, cnt_1}, exp_cnt1);
    chk("cnt_w4", {16'b0, cnt_4}, exp_cnt4);
`endif
  endtask

  // Inputs are stable across the edge; model advances on it, registers checked at the negedge.
  task automatic tick();
    logic       z1;
    logic [3:0] z4;
    z1 = ref1();
    z4 = nand_ref(a1_4, a2_4, a3_4, a4_4);
    @(posedge clk);
    if (rst) model_reset();
    else if (en) begin
      if (z1 != exp_q1 && exp_cnt1 < 3) exp_cnt1++;
      if (z4 != exp_q4 && exp_cnt4 < 65535) exp_cnt4++;
      exp_q1 = z1; exp_all1 = (z1 == 1'b0);
      exp_q4 = z4; exp_all4 = (z4 == 4'h0);
    end
    @(negedge clk);
    check_regs();
  endtask

  task automatic set1(input logic [3:0] v);
    {a1_1, a2_1, a3_1, a4_1} = v;
  endtask

  task automatic set4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                      input logic [3:0] d);
    a1_4 = a; a2_4 = b; a3_4 = c; a4_4 = d;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    set1(4'b0000); set4(4'h0, 4'h0, 4'h0, 4'h0);
    model_reset();
    #2;

    // Reset state with all-ones inputs, clock edges irrelevant
    set1(4'b1111);
    #1;
    chk("rst_zn", {31'b0, zn_1}, 32'd0);
    check_regs();

    // Exhaustive WIDTH=1 sweep while in reset
    for (int v = 0; v < 16; v++) begin
      set1(4'(v));
      #10;
      chk("sweep_zn", {31'b0, zn_1}, (v == 15) ? 32'd0 : 32'd1);
    end

    // Release reset, one enabled edge captures 1111
    set1(4'b1111); set4(4'hF, 4'hF, 4'hF, 4'hA);
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    #1 check_zn();
    chk("w4_dir_zn", {28'b0, zn_4}, 32'h5);
    tick();
    chk("dir_znq_w1", {31'b0, znq_1}, 32'd0);
    chk("dir_allhi_w1", {31'b0, allhi_1}, 32'd1);

    // WIDTH=4 all-ones gives zero and raises the flag
    set4(4'hF, 4'hF, 4'hF, 4'hF);
    #1 chk("w4_dir_zero", {28'b0, zn_4}, 32'h0);
    tick();
    chk("dir_allhi_w4", {31'b0, allhi_4}, 32'd1);

    // EN hold
    set1(4'b0000); tick();
    en = 1'b0; set1(4'b1111);
    repeat (3) tick();
    chk("hold_znq", {31'b0, znq_1}, 32'd1);
    en = 1'b1; tick();
    chk("hold_release", {31'b0, znq_1}, 32'd0);

    // Async reset between edges
    #2 rst = 1'b1;
    #1 model_reset();
    check_regs();
    #1 rst = 1'b0;

    // Toggle saturation with CNT_W=2: 5 alternating enabled edges
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      set1((k % 2 == 0) ? 4'b1111 : 4'b0000);
      tick();
    end
`ifdef NAND4_X4_TOGGLE_CNT_EN
    chk("cnt_sat", {30'b0, cnt_1}, 32'd3);
`endif

    // Randomized phase
    for (int n = 0; n < 60; n++) begin
      logic [3:0] r [4];
      for (int j = 0; j < 4; j++) r[j] = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
      set4(r[0], r[1], r[2], r[3]);
      set1(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        #1 rst = 1'b1;
        #1 model_reset();
        check_regs();
        rst = 1'b0;
      end
      #1 check_zn();
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/nand4_x4_cell.md
Name: nand4_x4_cell

Overview:
- Four-input NAND drive-strength-X4 cell wrapper for the standard-cell library model set.
- Provides a purely combinational NAND output, ZN, and a registered copy of that output for timing-closed fan-out.
- An optional toggle counter is available for activity and power characterisation.

Parameters:
- WIDTH, 1, bit width of each input vector and of ZN/ZN_Q; the NAND is applied bitwise.
- CNT_W, 16, width of the optional toggle counter.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- A1  input  WIDTH  NAND operand 1.
- A2  input  WIDTH  NAND operand 2.
- A3  input  WIDTH  NAND operand 3.
- A4  input  WIDTH  NAND operand 4.
- EN  input  1  load enable for ZN_Q.
- ZN  output  WIDTH  combinational result, ~(A1 & A2 & A3 & A4).
- ZN_Q  output  WIDTH  registered ZN.
- ALL_HI_Q  output  1  registered flag, 1 when every bit of ZN is 0.
- TOG_CNT  output  CNT_W  toggle count; present only with the optional feature.

Behaviour:
- ZN is purely combinational with zero cycles of latency. It is independent of clk, rst and EN.
- ZN is valid whenever the inputs are stable, including during reset.
- WIDTH=1 truth table: ZN=0 only for A1A2A3A4=1111; ZN=1 for all other 15 combinations (0000 through 1110).
- Bitwise rule: ZN[i] = ~(A1[i]&A2[i]&A3[i]&A4[i]) for each bit independently.
- X/Z handling: if any input bit is 0, that ZN bit is 1 even when other inputs are X. Otherwise X propagates, matching the gate primitive.
- ZN_Q on a rising clk with EN=1 loads ZN. With EN=0 it holds its value.
- ALL_HI_Q on a rising clk with EN=1 loads (ZN == 0). With EN=0 it holds its value.
- Registered latency is 1 cycle from inputs to ZN_Q and ALL_HI_Q.
- Reset values:
  - ZN_Q = all ones (the NAND of all-zero inputs).
  - ALL_HI_Q = 0.
  - TOG_CNT = 0.
- Asserting rst at any time, including mid-cycle, forces the reset values immediately.
- Deasserting rst: the first load happens at the first rising clk edge with rst=0 and EN=1.
- rst dominates EN.
- No handshake and no state machine.

Optional Feature:
- Macro: NAND4_X4_TOGGLE_CNT_EN.
- When defined:
  - TOG_CNT exists.
  - On each rising clk with EN=1, if the new ZN differs from the current ZN_Q in any bit, TOG_CNT increments by 1.
  - TOG_CNT saturates at 2^CNT_W-1 and does not wrap.
  - TOG_CNT is cleared asynchronously by rst.
- When not defined:
  - The TOG_CNT port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Exhaustive WIDTH=1 sweep of A1A2A3A4 from 0000 to 1111, sampling ZN 10 time units after each change -> ZN=1 for 0000 through 1110 and ZN=0 for 1111. No clock is needed.
- Reset with inputs 1111, rst=1, clk idle -> ZN_Q=1, ALL_HI_Q=0, ZN=0 immediately. Then deassert rst and apply one clk edge with EN=1 -> ZN_Q=0, ALL_HI_Q=1.
- EN hold: load 0000 (ZN_Q=1), set EN=0 and inputs 1111, clock 3 cycles -> ZN_Q stays 1 and ALL_HI_Q stays 0. Set EN=1 and clock 1 edge -> ZN_Q=0.
- Asynchronous reset mid-operation: with ZN_Q=0, pulse rst between clock edges -> ZN_Q=1 before the next edge.
- WIDTH=4 with A1=F, A2=F, A3=F, A4=A -> ZN=5. With A4=F -> ZN=0, and after 1 edge ALL_HI_Q=1.
- With NAND4_X4_TOGGLE_CNT_EN and CNT_W=2, alternate the inputs between 1111 and 0000 for 5 enabled edges after reset -> TOG_CNT=3 (saturated).
